// File: rtl/serial_add_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
//   Shared types and helpers for the bit-serial adder controller.
//   - sa_state_t : controller FSM states (IDLE -> SHIFT -> DONE -> IDLE)
//   - cnt_w()    : width of the bit counter for a given operand width
// ---------------------------------------------------------------------------
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sa_state_t;

   // One extra bit over $clog2 so the counter can always represent WIDTH-1,
   // including the degenerate WIDTH=1 case where $clog2 returns 0.
   function automatic int cnt_w(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// ---------------------------------------------------------------------------
// fa_bit
//   Purely combinational 1-bit full adder; the only arithmetic cell of the
//   serial adder, reused on every SHIFT cycle.
// Ports
//   a, b, cin : input bits
//   sum       : a ^ b ^ cin
//   cout      : majority(a, b, cin)
// ---------------------------------------------------------------------------
module fa_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder controller. Accepts one WIDTH-bit request (a, b, cin),
//   walks a single fa_bit cell across the operands LSB first over WIDTH
//   cycles, and presents {cout, sum} on a valid/ready output channel.
// Parameters
//   WIDTH     : operand/sum width, 1..64
// Ports
//   clk       : clock, all state updates on posedge
//   rst_n     : synchronous active-low reset
//   in_valid  : request present on a/b/cin
//   in_ready  : controller idle and able to accept
//   a, b, cin : operands, sampled only on accept
//   out_valid : result present on sum/cout
//   out_ready : downstream takes the result
//   sum, cout : a + b + cin; held until the next result is produced
//   busy      : high in SHIFT or DONE
//   ovf       : signed overflow, only when SERIAL_ADD_OVF_EN is defined
// Configuration
//   SERIAL_ADD_OVF_EN : adds the ovf output port
// ---------------------------------------------------------------------------
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
   output logic             busy,
   output logic             ovf
`else
   output logic             busy
`endif
);

   localparam int            CW       = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   sa_state_t        state;
   sa_state_t        state_next;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic [WIDTH-1:0] sum_shift;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] res_sum;
   logic             res_cout;
   logic             fa_s;
   logic             fa_co;
   logic             last_bit;
   logic             accept;

   // The single full-adder cell always looks at the LSBs of the operand
   // shift registers plus the running carry.
   fa_bit u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .sum  (fa_s),
      .cout (fa_co)
   );

   assign last_bit = (cnt == LAST_CNT);
   assign accept   = in_valid && (state == IDLE);

   // New sum bits enter at the MSB so that after WIDTH right shifts the
   // first (LSB) result bit has arrived at position 0. Written as a shift
   // plus a bit overwrite so WIDTH=1 needs no special casing.
   always_comb begin
      sum_shift            = sum_sr >> 1;
      sum_shift[WIDTH-1]   = fa_s;
   end

   // State register; reset drops any transaction in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs. DONE deliberately keeps in_ready low,
   // so a request arriving together with out_ready waits for the IDLE cycle.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_bit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: operands are captured only on accept, then shifted one bit per
   // SHIFT cycle. The finished result is copied into separate holding
   // registers on the last SHIFT cycle so sum/cout stay valid after retire
   // and while the next request is being computed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sr     <= '0;
         b_sr     <= '0;
         sum_sr   <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         res_sum  <= '0;
         res_cout <= 1'b0;
      end else begin
         if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
         end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= sum_shift;
            carry  <= fa_co;
            if (last_bit) begin
               res_sum  <= sum_shift;
               res_cout <= fa_co;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

   assign sum  = res_sum;
   assign cout = res_cout;

`ifdef SERIAL_ADD_OVF_EN
   // On the last SHIFT cycle the carry register holds the carry into the MSB
   // and the cell produces the carry out of it; their XOR is signed overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if ((state == SHIFT) && last_bit) begin
         ovf <= carry ^ fa_co;
      end
   end
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
//   Self-checking bench for serial_add_ctrl at WIDTH = 8, 1 and 32.
//   Expected results are pushed to per-instance queues when a request is
//   accepted and popped when the DUT retires a result.
//   Honours SERIAL_ADD_OVF_EN for the ovf port.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   // WIDTH = 8 instance
   logic        iv8, ir8, ov8, or8, ci8, co8, bz8;
   logic [7:0]  a8, b8, s8;
   // WIDTH = 1 instance
   logic        iv1, ir1, ov1, or1, ci1, co1, bz1;
   logic [0:0]  a1, b1, s1;
   // WIDTH = 32 instance
   logic        iv32, ir32, ov32, or32, ci32, co32, bz32;
   logic [31:0] a32, b32, s32;
`ifdef SERIAL_ADD_OVF_EN
   logic        ovf8, ovf1, ovf32;
`endif

   int vectors    = 0;
   int miscompares = 0;

   // Scoreboards: {ovf, cout, sum[63:0]}
   logic [65:0] q8[$];
   logic [65:0] q1[$];
   logic [65:0] q32[$];

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
      .a(a8), .b(b8), .cin(ci8), .out_valid(ov8), .out_ready(or8),
      .sum(s8), .cout(co8),
`ifdef SERIAL_ADD_OVF_EN
      .busy(bz8), .ovf(ovf8)
`else
      .busy(bz8)
`endif
   );

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
      .a(a1), .b(b1), .cin(ci1), .out_valid(ov1), .out_ready(or1),
      .sum(s1), .cout(co1),
`ifdef SERIAL_ADD_OVF_EN
      .busy(bz1), .ovf(ovf1)
`else
      .busy(bz1)
`endif
   );

   serial_add_ctrl #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
      .a(a32), .b(b32), .cin(ci32), .out_valid(ov32), .out_ready(or32),
      .sum(s32), .cout(co32),
`ifdef SERIAL_ADD_OVF_EN
      .busy(bz32), .ovf(ovf32)
`else
      .busy(bz32)
`endif
   );

   // Reference model of a w-bit add: returns {ovf, cout, sum}.
   function automatic logic [65:0] model(input int w, input logic [63:0] x,
                                         input logic [63:0] y, input logic c);
      logic [64:0] t;
      logic [65:0] r;
      logic [63:0] mask;
      mask  = (64'd1 << w) - 64'd1;
      t     = {1'b0, x & mask} + {1'b0, y & mask} + {64'd0, c};
      r     = '0;
      r[63:0] = t[63:0] & mask;
      r[64] = t[w];
      r[65] = (x[w-1] == y[w-1]) && (t[w-1] != x[w-1]);
      return r;
   endfunction

   // Waits on the 8-bit instance's out_valid with a cycle bound; returns the
   // number of negedges waited (200 means the bound expired).
   task automatic wait_valid8(output int cyc);
      cyc = 0;
      while (ov8 !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      iv8 = 0; or8 = 0; a8 = 0; b8 = 0; ci8 = 0;
      iv1 = 0; or1 = 0; a1 = 0; b1 = 0; ci1 = 0;
      iv32 = 0; or32 = 0; a32 = 0; b32 = 0; ci32 = 0;
      repeat (3) @(negedge clk);
      vectors++;
      if (ir8 !== 1'b1 || ov8 !== 1'b0 || bz8 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_hs8: got ir=%b ov=%b busy=%b want 1 0 0", ir8, ov8, bz8);
      end
      vectors++;
      if (s8 !== 8'h00 || co8 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_res8: got sum=%h cout=%b want 00 0", s8, co8);
      end
      vectors++;
      if (ir1 !== 1'b1 || ov1 !== 1'b0 || ir32 !== 1'b1 || ov32 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_hs1_32: got ir1=%b ov1=%b ir32=%b ov32=%b want 1 0 1 0",
                  ir1, ov1, ir32, ov32);
      end
`ifdef SERIAL_ADD_OVF_EN
      vectors++;
      if (ovf8 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_ovf8: got %b want 0", ovf8);
      end
`endif
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_carry_wrap;
      int cyc;
      logic [65:0] exp;
      a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
      q8.push_back(model(8, 64'(a8), 64'(b8), ci8));
      @(negedge clk);
      iv8 = 1'b0;
      wait_valid8(cyc);
      vectors++;
      if (cyc !== 8) begin
         miscompares++;
         $display("[TB] FAIL latency8: got %0d cycles want 8", cyc);
      end
      exp = (q8.size() > 0) ? q8.pop_front() : '1;
      vectors++;
      if (s8 !== exp[7:0] || co8 !== exp[64]) begin
         miscompares++;
         $display("[TB] FAIL carry_wrap: got cout=%b sum=%h want cout=%b sum=%h",
                  co8, s8, exp[64], exp[7:0]);
      end
      @(negedge clk);
      vectors++;
      if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL retire8: got ov=%b ir=%b want 0 1", ov8, ir8);
      end
   endtask

   task automatic test_overflow;
      int cyc;
      logic [65:0] exp;
      a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
      q8.push_back(model(8, 64'(a8), 64'(b8), ci8));
      @(negedge clk);
      iv8 = 1'b0;
      wait_valid8(cyc);
      exp = (q8.size() > 0) ? q8.pop_front() : '1;
      vectors++;
      if (ov8 !== 1'b1 || s8 !== exp[7:0] || co8 !== exp[64]) begin
         miscompares++;
         $display("[TB] FAIL overflow_sum: got ov=%b cout=%b sum=%h want 1 %b %h",
                  ov8, co8, s8, exp[64], exp[7:0]);
      end
`ifdef SERIAL_ADD_OVF_EN
      vectors++;
      if (ovf8 !== exp[65]) begin
         miscompares++;
         $display("[TB] FAIL overflow_ovf: got %b want %b", ovf8, exp[65]);
      end
`endif
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      int cyc;
      logic [65:0] exp;
      a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1; iv8 = 1'b1; or8 = 1'b0;
      q8.push_back(model(8, 64'(a8), 64'(b8), ci8));
      @(negedge clk);
      iv8 = 1'b0;
      wait_valid8(cyc);
      exp = (q8.size() > 0) ? q8.pop_front() : '1;
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (ov8 !== 1'b1 || ir8 !== 1'b0 || s8 !== exp[7:0] || co8 !== exp[64]) begin
            miscompares++;
            $display("[TB] FAIL hold_%0d: got ov=%b ir=%b cout=%b sum=%h want 1 0 %b %h",
                     i, ov8, ir8, co8, s8, exp[64], exp[7:0]);
         end
         @(negedge clk);
      end
      or8 = 1'b1;
      vectors++;
      if (ov8 !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL hold_end: got ov=%b want 1", ov8);
      end
      @(negedge clk);
      vectors++;
      if (ov8 !== 1'b0 || ir8 !== 1'b1 || s8 !== exp[7:0]) begin
         miscompares++;
         $display("[TB] FAIL hold_retire: got ov=%b ir=%b sum=%h want 0 1 %h",
                  ov8, ir8, s8, exp[7:0]);
      end
   endtask

   task automatic test_back_to_back;
      int cyc;
      logic [65:0] exp;
      a8 = 8'h21; b8 = 8'h10; ci8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
      q8.push_back(model(8, 64'(a8), 64'(b8), ci8));
      @(negedge clk);
      cyc = 0;
      while (ov8 !== 1'b1 && cyc < 200) begin
         vectors++;
         if (ir8 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL shift_ready_%0d: got %b want 0", cyc, ir8);
         end
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         ci8 = 1'($urandom_range(0, 1));
         @(negedge clk);
         cyc++;
      end
      exp = (q8.size() > 0) ? q8.pop_front() : '1;
      vectors++;
      if (ov8 !== 1'b1 || s8 !== exp[7:0] || co8 !== exp[64]) begin
         miscompares++;
         $display("[TB] FAIL b2b_first: got ov=%b cout=%b sum=%h want 1 %b %h",
                  ov8, co8, s8, exp[64], exp[7:0]);
      end
      // in_valid stays high across the retire edge; it must not be taken in DONE
      a8 = 8'h05; b8 = 8'h06; ci8 = 1'b1;
      @(negedge clk);
      vectors++;
      if (ov8 !== 1'b0 || bz8 !== 1'b0 || ir8 !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL b2b_no_accept_done: got ov=%b busy=%b ir=%b want 0 0 1",
                  ov8, bz8, ir8);
      end
      q8.push_back(model(8, 64'(a8), 64'(b8), ci8));
      @(negedge clk);
      iv8 = 1'b0;
      vectors++;
      if (bz8 !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL b2b_accept_idle: got busy=%b want 1", bz8);
      end
      wait_valid8(cyc);
      exp = (q8.size() > 0) ? q8.pop_front() : '1;
      vectors++;
      if (cyc !== 8 || s8 !== exp[7:0] || co8 !== exp[64]) begin
         miscompares++;
         $display("[TB] FAIL b2b_second: got cyc=%0d cout=%b sum=%h want 8 %b %h",
                  cyc, co8, s8, exp[64], exp[7:0]);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_shift;
      logic seen;
      a8 = 8'h55; b8 = 8'h22; ci8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
      @(negedge clk);
      iv8 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      vectors++;
      if (ir8 !== 1'b1 || ov8 !== 1'b0 || bz8 !== 1'b0 || s8 !== 8'h00 || co8 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL mid_reset: got ir=%b ov=%b busy=%b sum=%h cout=%b want 1 0 0 00 0",
                  ir8, ov8, bz8, s8, co8);
      end
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ov8 !== 1'b0) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL mid_reset_no_result: got out_valid=1 want 0");
      end
   endtask

   task automatic test_random1;
      int accepted = 0;
      int retired  = 0;
      int cyc      = 0;
      logic [65:0] exp;
      while (retired < 1000 && cyc < 20000) begin
         or1 = ($urandom_range(0, 9) < 7);
         if (accepted < 1000) begin
            iv1 = ($urandom_range(0, 9) < 7);
            a1  = 1'($urandom_range(0, 1));
            b1  = 1'($urandom_range(0, 1));
            ci1 = 1'($urandom_range(0, 1));
         end else begin
            iv1 = 1'b0;
         end
         if (ov1 === 1'b1 && or1) begin
            exp = (q1.size() > 0) ? q1.pop_front() : '1;
            vectors++;
            if (s1 !== exp[0:0] || co1 !== exp[64]) begin
               miscompares++;
               $display("[TB] FAIL rand1_%0d: got cout=%b sum=%b want cout=%b sum=%b",
                        retired, co1, s1, exp[64], exp[0]);
            end
`ifdef SERIAL_ADD_OVF_EN
            vectors++;
            if (ovf1 !== exp[65]) begin
               miscompares++;
               $display("[TB] FAIL rand1_ovf_%0d: got %b want %b", retired, ovf1, exp[65]);
            end
`endif
            retired++;
         end
         if (iv1 && ir1 === 1'b1) begin
            q1.push_back(model(1, 64'(a1), 64'(b1), ci1));
            accepted++;
         end
         @(negedge clk);
         cyc++;
      end
      iv1 = 1'b0;
      vectors++;
      if (retired != 1000) begin
         miscompares++;
         $display("[TB] FAIL rand1_timeout: got %0d results want 1000", retired);
      end
   endtask

   task automatic test_random32;
      int accepted = 0;
      int retired  = 0;
      int cyc      = 0;
      logic [65:0] exp;
      while (retired < 1000 && cyc < 60000) begin
         or32 = ($urandom_range(0, 9) < 7);
         if (accepted < 1000) begin
            iv32 = ($urandom_range(0, 9) < 7);
            a32  = $urandom;
            b32  = $urandom;
            ci32 = 1'($urandom_range(0, 1));
         end else begin
            iv32 = 1'b0;
         end
         if (ov32 === 1'b1 && or32) begin
            exp = (q32.size() > 0) ? q32.pop_front() : '1;
            vectors++;
            if (s32 !== exp[31:0] || co32 !== exp[64]) begin
               miscompares++;
               $display("[TB] FAIL rand32_%0d: got cout=%b sum=%h want cout=%b sum=%h",
                        retired, co32, s32, exp[64], exp[31:0]);
            end
`ifdef SERIAL_ADD_OVF_EN
            vectors++;
            if (ovf32 !== exp[65]) begin
               miscompares++;
               $display("[TB] FAIL rand32_ovf_%0d: got %b want %b", retired, ovf32, exp[65]);
            end
`endif
            retired++;
         end
         if (iv32 && ir32 === 1'b1) begin
            q32.push_back(model(32, 64'(a32), 64'(b32), ci32));
            accepted++;
         end
         @(negedge clk);
         cyc++;
      end
      iv32 = 1'b0;
      vectors++;
      if (retired != 1000) begin
         miscompares++;
         $display("[TB] FAIL rand32_timeout: got %0d results want 1000", retired);
      end
   endtask

   // Directed scenarios on the 8-bit instance, then randomized runs on the
   // 1-bit and 32-bit instances.
   initial begin
      @(negedge clk);
      test_reset();
      test_carry_wrap();
      test_overflow();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_shift();
      test_random1();
      test_random32();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
